alu_exec_sequencer: RTL and testbench
=====================================

// Module: alu_exec_sequencer
// PURPOSE
//  Sequencer that sits directly upstream of the combinational 8-bit arithmetic engine and also consumes its result.
//  - Accepts one instruction at a time over a valid/ready handshake.
//  - Reads operands from a small local register file and drives A/B/opcode into the engine.
//  - Captures the engine result, writes it back to the register file and returns it on a valid/ready response port.
// PARAMETERS
//  NUM_REGS   4   register-file depth; power of two, minimum 2
//  REG_AW     2   register index width; must equal $clog2(NUM_REGS)
// PORTS
//  clk          in   1       single clock; all state on rising edge
//  rst_n        in   1       synchronous reset, active-low
//  instr_valid  in   1       instruction present
//  instr_ready  out  1       sequencer can accept (high only in IDLE)
//  instr_op     in   3       0 OR, 1 NAND, 2 NOR, 3 AND, 4 ADD, 5 SUB, 6 LOADI, 7 illegal
//  instr_rd     in   REG_AW  destination register
//  instr_rs1    in   REG_AW  source A register
//  instr_rs2    in   REG_AW  source B register
//  instr_imm    in   8       immediate, used by LOADI only
//  alu_a        out  8       engine operand A (registered)
//  alu_b        out  8       engine operand B (registered)
//  alu_opcode   out  3       engine opcode (registered)
//  alu_result   in   8       engine combinational result
//  res_valid    out  1       response present
//  res_ready    in   1       downstream accepts response
//  res_rd       out  REG_AW  destination of the response
//  res_data     out  8       written value
//  res_err      out  1       1 = illegal opcode; no write performed
// BEHAVIOUR
//  - Reset: clk edge with rst_n=0 forces the following, regardless of state (reset mid-operation drops any in-flight instruction):
//    - state IDLE; all register-file entries 0.
//    - alu_a/alu_b/alu_opcode = 0; res_valid = 0; res_rd = 0; res_data = 0; res_err = 0; instr_ready = 0 during reset.
//  - FSM IDLE -> EXEC -> RESP -> IDLE:
//    - IDLE: instr_ready=1. On instr_valid, latch the instruction and load alu_a=rf[rs1], alu_b=rf[rs2], alu_opcode=op; go EXEC.
//    - EXEC, one cycle: sample alu_result (LOADI: instr_imm; op 7: no sample).
//      - op 0-6: write rf[rd] and load res_data/res_rd.
//      - op 7: res_err=1, res_data=0, rf unchanged.
//      - Set res_valid=1; go RESP.
//    - RESP: hold res_* stable until res_ready=1; on that edge res_valid=0 and go IDLE. res_ready while res_valid=0 is ignored.
//  - Latency: accept edge to res_valid = 2 cycles; minimum 3 cycles per instruction.
//  - Throughput:
//    - Write-back completes before the next accept, so back-to-back dependent instructions see updated values.
//    - rs1==rs2==rd is legal.
//  - Arithmetic: 8-bit modulo; ADD wraps (0xFF+0x01=0x00); SUB wraps (0x00-0x01=0xFF).
//  - alu_a/alu_b/alu_opcode hold their last values outside EXEC; no other interaction with the engine.
// CONFIGURATION
//  ALU_SEQ_FLAGS_EN defined:
//    - Adds outputs res_zero (res_data==0) and res_carry, valid with res_valid.
//    - res_carry = carry-out of {1'b0,A}+{1'b0,B} for ADD; borrow (A<B) for SUB; 0 otherwise.
//    - Carry is computed locally from the latched operands; the engine stays 8-bit.
//  ALU_SEQ_FLAGS_EN undefined: ports absent, no flag logic.
// STRUCTURE
//  - Package alu_pkg: opcode localparams (OP_OR..OP_LOADI, OP_ILL) and state enum (S_IDLE, S_EXEC, S_RESP), shared with the engine bench.
//  - Sub-module alu_regfile: NUM_REGS x 8, two asynchronous read ports, one synchronous write port, synchronous active-low clear.
//  - Top instantiates alu_regfile plus the FSM. The engine is instantiated outside, next to this block.
// TESTING (bench instantiates the engine and connects alu_* ports)
//  1. Reset, then LOADI r1=0x0F, LOADI r2=0xF0, OR r3=r1,r2 -> res_data 0xFF, rd=3, err=0; each response 2 cycles after accept.
//  2. r1=0xFF, r2=0x01: ADD r0 -> 0x00 (carry=1, zero=1 with FLAGS_EN); SUB r0=r2-r1 -> 0x02 (borrow=1).
//  3. NAND/NOR/AND with r1=0xAA, r2=0xCC -> 0x77, 0x11, 0x88.
//  4. Hold res_ready=0 for 5 cycles -> res_* stable, instr_ready=0 throughout; release -> instr_ready=1 on the next cycle.
//  5. op=7 -> res_err=1, res_data=0; readback via OR rX,rX shows rd unchanged.
//  6. Drive rst_n=0 during EXEC -> next cycle IDLE, res_valid=0, all regs read back 0.

Source files
------------

// File: rtl/alu_exec_sequencer_pkg.sv
// Shared opcode and FSM-state definitions for the ALU execution sequencer and its engine bench.
// Optional flag outputs are enabled with the ALU_SEQ_FLAGS_EN macro.
package alu_pkg;

  localparam logic [2:0] OP_OR    = 3'd0;
  localparam logic [2:0] OP_NAND  = 3'd1;
  localparam logic [2:0] OP_NOR   = 3'd2;
  localparam logic [2:0] OP_AND   = 3'd3;
  localparam logic [2:0] OP_ADD   = 3'd4;
  localparam logic [2:0] OP_SUB   = 3'd5;
  localparam logic [2:0] OP_LOADI = 3'd6;
  localparam logic [2:0] OP_ILL   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Every opcode except the illegal one writes its result back.
  function automatic logic op_writes(input logic [2:0] op);
    return op != OP_ILL;
  endfunction

endpackage

// File: rtl/alu_exec_sequencer_if.sv
// Instruction, engine and response signals of the ALU execution sequencer.
// res_zero/res_carry exist only when ALU_SEQ_FLAGS_EN is defined.
interface alu_exec_sequencer_if #(
  parameter int REG_AW = 2
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // the producer holds valid and payload stable until then, and ready never waits on valid.
  logic              instr_valid;
  logic              instr_ready;
  logic [2:0]        instr_op;
  logic [REG_AW-1:0] instr_rd;
  logic [REG_AW-1:0] instr_rs1;
  logic [REG_AW-1:0] instr_rs2;
  logic [7:0]        instr_imm;

  logic [7:0]        alu_a;
  logic [7:0]        alu_b;
  logic [2:0]        alu_opcode;
  logic [7:0]        alu_result;

  logic              res_valid;
  logic              res_ready;
  logic [REG_AW-1:0] res_rd;
  logic [7:0]        res_data;
  logic              res_err;
`ifdef ALU_SEQ_FLAGS_EN
  logic              res_zero;
  logic              res_carry;
`endif

  modport slave (
    input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm,
    output instr_ready,
    output alu_a, alu_b, alu_opcode,
    input  alu_result,
    output res_valid, res_rd, res_data, res_err,
`ifdef ALU_SEQ_FLAGS_EN
    output res_zero, res_carry,
`endif
    input  res_ready
  );

  modport master (
    output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm,
    input  instr_ready,
    input  alu_a, alu_b, alu_opcode,
    output alu_result,
    input  res_valid, res_rd, res_data, res_err,
`ifdef ALU_SEQ_FLAGS_EN
    input  res_zero, res_carry,
`endif
    output res_ready
  );

endinterface

// File: rtl/alu_regfile.sv
// NUM_REGS x 8 register file: two asynchronous read ports, one synchronous write port,
// synchronous active-low clear of every entry.
module alu_regfile #(
  parameter int NUM_REGS = 4,
  parameter int REG_AW   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [7:0]        i_wdata,
  input  logic [REG_AW-1:0] i_raddr_a,
  output logic [7:0]        o_rdata_a,
  input  logic [REG_AW-1:0] i_raddr_b,
  output logic [7:0]        o_rdata_b
);

  logic [7:0] r_mem [NUM_REGS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= 8'h00;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/alu_exec_sequencer.sv
// Sequencer in front of the combinational 8-bit engine: IDLE -> EXEC -> RESP.
// ALU_SEQ_FLAGS_EN adds res_zero/res_carry, computed locally from the latched operands.
module alu_exec_sequencer
  import alu_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int REG_AW   = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  alu_exec_sequencer_if.slave bus,
  output state_t o_dbg_state
);

  state_t            r_state;
  logic              r_instr_ready;
  logic [7:0]        r_alu_a;
  logic [7:0]        r_alu_b;
  logic [2:0]        r_alu_opcode;
  logic [REG_AW-1:0] r_rd;
  logic [7:0]        r_imm;
  logic              r_res_valid;
  logic [REG_AW-1:0] r_res_rd;
  logic [7:0]        r_res_data;
  logic              r_res_err;

  logic [7:0]        w_rdata_a;
  logic [7:0]        w_rdata_b;
  logic              w_we;
  logic [7:0]        w_wdata;
  logic              w_accept;

  // LOADI bypasses the engine; the engine output is ignored for that opcode.
  assign w_wdata  = (r_alu_opcode == OP_LOADI) ? r_imm : bus.alu_result;
  assign w_we     = (r_state == S_EXEC) && op_writes(r_alu_opcode);
  assign w_accept = (r_state == S_IDLE) && r_instr_ready && bus.instr_valid;

  alu_regfile #(
    .NUM_REGS (NUM_REGS),
    .REG_AW   (REG_AW)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_we      (w_we),
    .i_waddr   (r_rd),
    .i_wdata   (w_wdata),
    .i_raddr_a (bus.instr_rs1),
    .o_rdata_a (w_rdata_a),
    .i_raddr_b (bus.instr_rs2),
    .o_rdata_b (w_rdata_b)
  );

`ifdef ALU_SEQ_FLAGS_EN
  logic [8:0] w_sum9;
  logic       w_carry;
  logic       r_res_zero;
  logic       r_res_carry;

  assign w_sum9  = {1'b0, r_alu_a} + {1'b0, r_alu_b};
  assign w_carry = (r_alu_opcode == OP_ADD) ? w_sum9[8] :
                   (r_alu_opcode == OP_SUB) ? (r_alu_a < r_alu_b) : 1'b0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_res_zero  <= 1'b0;
      r_res_carry <= 1'b0;
    end else if (r_state == S_EXEC) begin
      r_res_zero  <= op_writes(r_alu_opcode) ? (w_wdata == 8'h00) : 1'b1;
      r_res_carry <= op_writes(r_alu_opcode) ? w_carry : 1'b0;
    end
  end

  assign bus.res_zero  = r_res_zero;
  assign bus.res_carry = r_res_carry;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_instr_ready <= 1'b0;
      r_alu_a       <= 8'h00;
      r_alu_b       <= 8'h00;
      r_alu_opcode  <= 3'd0;
      r_rd          <= '0;
      r_imm         <= 8'h00;
      r_res_valid   <= 1'b0;
      r_res_rd      <= '0;
      r_res_data    <= 8'h00;
      r_res_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_alu_a       <= w_rdata_a;
            r_alu_b       <= w_rdata_b;
            r_alu_opcode  <= bus.instr_op;
            r_rd          <= bus.instr_rd;
            r_imm         <= bus.instr_imm;
            r_instr_ready <= 1'b0;
            r_state       <= S_EXEC;
          end else begin
            r_instr_ready <= 1'b1;
          end
        end
        S_EXEC: begin
          r_res_valid <= 1'b1;
          r_res_rd    <= r_rd;
          if (op_writes(r_alu_opcode)) begin
            r_res_data <= w_wdata;
            r_res_err  <= 1'b0;
          end else begin
            r_res_data <= 8'h00;
            r_res_err  <= 1'b1;
          end
          r_state <= S_RESP;
        end
        S_RESP: begin
          // Write-back already happened in EXEC, so the next accept sees it.
          if (bus.res_ready) begin
            r_res_valid   <= 1'b0;
            r_instr_ready <= 1'b1;
            r_state       <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.instr_ready = r_instr_ready;
  assign bus.alu_a       = r_alu_a;
  assign bus.alu_b       = r_alu_b;
  assign bus.alu_opcode  = r_alu_opcode;
  assign bus.res_valid   = r_res_valid;
  assign bus.res_rd      = r_res_rd;
  assign bus.res_data    = r_res_data;
  assign bus.res_err     = r_res_err;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// Directed bench for alu_exec_sequencer with a behavioural 8-bit engine on the alu_* signals.
// Flag checks are compiled in when ALU_SEQ_FLAGS_EN is defined.
module tb_alu_exec_sequencer;
  import alu_pkg::*;

  logic   clk;
  logic   rst_n;
  state_t dbg_state;
  int     n_vec;
  int     n_err;
  logic [7:0] exp_q[$];

  alu_exec_sequencer_if #(.REG_AW(2)) bus ();

  alu_exec_sequencer #(
    .NUM_REGS (4),
    .REG_AW   (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // engine
  always_comb begin
    bus.alu_result = 8'h00;
    case (bus.alu_opcode)
      OP_OR:   bus.alu_result = bus.alu_a | bus.alu_b;
      OP_NAND: bus.alu_result = ~(bus.alu_a & bus.alu_b);
      OP_NOR:  bus.alu_result = ~(bus.alu_a | bus.alu_b);
      OP_AND:  bus.alu_result = bus.alu_a & bus.alu_b;
      OP_ADD:  bus.alu_result = bus.alu_a + bus.alu_b;
      OP_SUB:  bus.alu_result = bus.alu_a - bus.alu_b;
      default: bus.alu_result = 8'h00;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.instr_valid = 1'b0;
    bus.res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
    chk("rst_instr_ready", 32'(bus.instr_ready), 32'd0);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_res_data", 32'(bus.res_data), 32'd0);
    chk("rst_res_rd", 32'(bus.res_rd), 32'd0);
    chk("rst_res_err", 32'(bus.res_err), 32'd0);
    chk("rst_alu_a", 32'(bus.alu_a), 32'd0);
    chk("rst_alu_b", 32'(bus.alu_b), 32'd0);
    chk("rst_alu_opcode", 32'(bus.alu_opcode), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // driver: issue one instruction, check its response, hold res_ready low for 'hold' cycles
  task automatic do_instr(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                          input logic [1:0] rs2, input logic [7:0] imm, input logic [7:0] exp_data,
                          input logic exp_err, input logic exp_carry, input int hold);
    int lat;
    logic [7:0] exp_d;
    exp_q.push_back(exp_data);
    @(negedge clk);
    bus.instr_op    = op;
    bus.instr_rd    = rd;
    bus.instr_rs1   = rs1;
    bus.instr_rs2   = rs2;
    bus.instr_imm   = imm;
    bus.instr_valid = 1'b1;
    for (int i = 0; i < 20 && !bus.instr_ready; i++) @(negedge clk);
    chk("instr_ready_wait", 32'(bus.instr_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("exec_state", 32'(dbg_state), 32'(S_EXEC));
    chk("alu_opcode", 32'(bus.alu_opcode), 32'(op));
    @(negedge clk);
    bus.instr_valid = 1'b0;
    lat = 1;
    while (!bus.res_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    exp_d = exp_q.pop_front();
    chk("latency", 32'(lat), 32'd2);
    chk("res_valid", 32'(bus.res_valid), 32'd1);
    chk("res_data", 32'(bus.res_data), 32'(exp_d));
    chk("res_rd", 32'(bus.res_rd), 32'(rd));
    chk("res_err", 32'(bus.res_err), 32'(exp_err));
`ifdef ALU_SEQ_FLAGS_EN
    chk("res_zero", 32'(bus.res_zero), 32'(exp_d == 8'h00));
    chk("res_carry", 32'(bus.res_carry), 32'(exp_carry));
`else
    if (exp_carry === 1'bx) $display("note: carry expectation unknown");
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(bus.res_valid), 32'd1);
      chk("hold_data", 32'(bus.res_data), 32'(exp_d));
      chk("hold_rd", 32'(bus.res_rd), 32'(rd));
      chk("hold_instr_ready", 32'(bus.instr_ready), 32'd0);
    end
    @(negedge clk);
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    chk("post_res_valid", 32'(bus.res_valid), 32'd0);
    chk("post_state", 32'(dbg_state), 32'(S_IDLE));
    chk("post_instr_ready", 32'(bus.instr_ready), 32'd1);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr_op    = 3'd0;
    bus.instr_rd    = 2'd0;
    bus.instr_rs1   = 2'd0;
    bus.instr_rs2   = 2'd0;
    bus.instr_imm   = 8'h00;
    bus.res_ready   = 1'b0;

    // 1: loads and OR
    apply_reset();
    do_instr(OP_LOADI, 2'd1, 2'd0, 2'd0, 8'h0F, 8'h0F, 1'b0, 1'b0, 0);
    do_instr(OP_LOADI, 2'd2, 2'd0, 2'd0, 8'hF0, 8'hF0, 1'b0, 1'b0, 0);
    do_instr(OP_OR,    2'd3, 2'd1, 2'd2, 8'h00, 8'hFF, 1'b0, 1'b0, 0);
    chk("alu_a_held", 32'(bus.alu_a), 32'h0F);
    chk("alu_b_held", 32'(bus.alu_b), 32'hF0);

    // 2: ADD wrap with carry, SUB with borrow
    do_instr(OP_LOADI, 2'd1, 2'd0, 2'd0, 8'hFF, 8'hFF, 1'b0, 1'b0, 0);
    do_instr(OP_LOADI, 2'd2, 2'd0, 2'd0, 8'h01, 8'h01, 1'b0, 1'b0, 0);
    do_instr(OP_ADD,   2'd0, 2'd1, 2'd2, 8'h00, 8'h00, 1'b0, 1'b1, 0);
    do_instr(OP_SUB,   2'd0, 2'd2, 2'd1, 8'h00, 8'h02, 1'b0, 1'b1, 0);

    // SUB 0x00-0x01 wraps; rs1==rs2==rd doubling uses the just-written value
    do_instr(OP_LOADI, 2'd0, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0, 0);
    do_instr(OP_LOADI, 2'd1, 2'd0, 2'd0, 8'h01, 8'h01, 1'b0, 1'b0, 0);
    do_instr(OP_SUB,   2'd2, 2'd0, 2'd1, 8'h00, 8'hFF, 1'b0, 1'b1, 0);
    do_instr(OP_ADD,   2'd2, 2'd2, 2'd2, 8'h00, 8'hFE, 1'b0, 1'b1, 0);

    // 3 and 4: logic ops, the last held under res_ready=0 for 5 cycles
    do_instr(OP_LOADI, 2'd1, 2'd0, 2'd0, 8'hAA, 8'hAA, 1'b0, 1'b0, 0);
    do_instr(OP_LOADI, 2'd2, 2'd0, 2'd0, 8'hCC, 8'hCC, 1'b0, 1'b0, 0);
    do_instr(OP_NAND,  2'd3, 2'd1, 2'd2, 8'h00, 8'h77, 1'b0, 1'b0, 0);
    do_instr(OP_NOR,   2'd3, 2'd1, 2'd2, 8'h00, 8'h11, 1'b0, 1'b0, 0);
    do_instr(OP_AND,   2'd3, 2'd1, 2'd2, 8'h00, 8'h88, 1'b0, 1'b0, 5);

    // 5: illegal opcode leaves r3 untouched
    do_instr(OP_ILL,   2'd3, 2'd1, 2'd2, 8'h55, 8'h00, 1'b1, 1'b0, 0);
    do_instr(OP_OR,    2'd3, 2'd3, 2'd3, 8'h00, 8'h88, 1'b0, 1'b0, 0);

    // 6: reset while in EXEC
    @(negedge clk);
    bus.instr_op    = OP_ADD;
    bus.instr_rd    = 2'd0;
    bus.instr_rs1   = 2'd1;
    bus.instr_rs2   = 2'd2;
    bus.instr_valid = 1'b1;
    for (int i = 0; i < 20 && !bus.instr_ready; i++) @(negedge clk);
    chk("mid_ready_wait", 32'(bus.instr_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("mid_exec_state", 32'(dbg_state), 32'(S_EXEC));
    @(negedge clk);
    bus.instr_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_state", 32'(dbg_state), 32'(S_IDLE));
    chk("mid_rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("mid_rst_instr_ready", 32'(bus.instr_ready), 32'd0);
    chk("mid_rst_alu_a", 32'(bus.alu_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < 4; r++) begin
      do_instr(OP_OR, 2'(r), 2'(r), 2'(r), 8'h00, 8'h00, 1'b0, 1'b0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
